// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared CPU datapath widths, ALU opcode type and register constants
package cpu_defs_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int OP_W   = 8;
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   typedef logic [OP_W-1:0] alu_op_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: one operand priority mux ($zero, EX forward, MEM forward, regfile)
module fwd_sel #(
   parameter int DATA_W = cpu_defs_pkg::DATA_W,
   parameter int ADDR_W = cpu_defs_pkg::ADDR_W
) (
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              ex_hit_i,
   input  logic [ADDR_W-1:0] ex_waddr_i,
   input  logic [DATA_W-1:0] ex_data_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_waddr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] src_o
);
   import cpu_defs_pkg::REG_ZERO;
   // first matching source wins; $zero and unread ports always yield 0
   always_comb begin
      src_o = (!re_i || raddr_i == ADDR_W'(REG_ZERO)) ? '0
            : (ex_hit_i && ex_waddr_i == raddr_i)     ? ex_data_i
            : (mem_we_i && mem_waddr_i == raddr_i)    ? mem_wdata_i
            :                                           rdata_i;
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding and load-use bubble
module id_ex_stage #(
   parameter int DATA_W = cpu_defs_pkg::DATA_W,
   parameter int ADDR_W = cpu_defs_pkg::ADDR_W,
   parameter int OP_W   = cpu_defs_pkg::OP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_re1,
   input  logic              id_re2,
   input  logic [ADDR_W-1:0] id_raddr1,
   input  logic [ADDR_W-1:0] id_raddr2,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_wreg,
   input  logic [ADDR_W-1:0] id_waddr,
   input  logic              id_mem_read,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic              mem_fwd_we,
   input  logic [ADDR_W-1:0] mem_fwd_waddr,
   input  logic [DATA_W-1:0] mem_fwd_wdata,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [DATA_W-1:0] ex_pc,
   output logic [OP_W-1:0]   ex_alu_op,
   output logic [DATA_W-1:0] ex_imm,
   output logic              ex_wreg,
   output logic [ADDR_W-1:0] ex_waddr,
   output logic              ex_mem_read,
   output logic [DATA_W-1:0] ex_src1,
   output logic [DATA_W-1:0] ex_src2
);
   import cpu_defs_pkg::REG_ZERO;
   logic              ex_valid_q, ex_valid_d;
   logic [DATA_W-1:0] ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d;
   logic [OP_W-1:0]   ex_alu_op_q, ex_alu_op_d;
   logic              ex_wreg_q, ex_wreg_d, ex_mem_read_q, ex_mem_read_d;
   logic [ADDR_W-1:0] ex_waddr_q, ex_waddr_d;
   logic [DATA_W-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
   logic [DATA_W-1:0] src1, src2;
   logic              hz, fire_in, ex_hit;

   // only a held non-load result can be forwarded; load data arrives later via MEM
   assign ex_hit = ex_valid_q & ex_wreg_q & ~ex_mem_read_q;

   fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
      .re_i(id_re1), .raddr_i(id_raddr1), .rdata_i(id_rdata1),
      .ex_hit_i(ex_hit), .ex_waddr_i(ex_waddr_q), .ex_data_i(ex_fwd_data),
      .mem_we_i(mem_fwd_we), .mem_waddr_i(mem_fwd_waddr), .mem_wdata_i(mem_fwd_wdata),
      .src_o(src1)
   );

   fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
      .re_i(id_re2), .raddr_i(id_raddr2), .rdata_i(id_rdata2),
      .ex_hit_i(ex_hit), .ex_waddr_i(ex_waddr_q), .ex_data_i(ex_fwd_data),
      .mem_we_i(mem_fwd_we), .mem_waddr_i(mem_fwd_waddr), .mem_wdata_i(mem_fwd_wdata),
      .src_o(src2)
   );

   // load-use stall and acceptance; a stalled ID instruction simply retries
   always_comb begin
      hz = id_valid_i & ex_valid_q & ex_mem_read_q & ex_wreg_q
         & (ex_waddr_q != ADDR_W'(REG_ZERO))
         & ((id_re1 & (id_raddr1 == ex_waddr_q)) | (id_re2 & (id_raddr2 == ex_waddr_q)));
      id_ready_o = ~flush & ~hz & (~ex_valid_q | ex_ready_i);
      fire_in    = id_valid_i & id_ready_o;
   end

   // capture on accept, drain on consume (bubble on stall), flush kills the entry
   always_comb begin
      ex_valid_d    = flush ? 1'b0 : fire_in ? 1'b1 : ex_valid_q & ~ex_ready_i;
      ex_pc_d       = fire_in ? id_pc       : ex_pc_q;
      ex_alu_op_d   = fire_in ? id_alu_op   : ex_alu_op_q;
      ex_imm_d      = fire_in ? id_imm      : ex_imm_q;
      ex_wreg_d     = fire_in ? id_wreg     : ex_wreg_q;
      ex_waddr_d    = fire_in ? id_waddr    : ex_waddr_q;
      ex_mem_read_d = fire_in ? id_mem_read : ex_mem_read_q;
      ex_src1_d     = fire_in ? src1        : ex_src1_q;
      ex_src2_d     = fire_in ? src2        : ex_src2_q;
   end

   // pipeline register; reset clears everything and drops any held instruction
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ex_pc_q       <= '0;
         ex_alu_op_q   <= '0;
         ex_imm_q      <= '0;
         ex_wreg_q     <= 1'b0;
         ex_waddr_q    <= '0;
         ex_mem_read_q <= 1'b0;
         ex_src1_q     <= '0;
         ex_src2_q     <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_pc_q       <= ex_pc_d;
         ex_alu_op_q   <= ex_alu_op_d;
         ex_imm_q      <= ex_imm_d;
         ex_wreg_q     <= ex_wreg_d;
         ex_waddr_q    <= ex_waddr_d;
         ex_mem_read_q <= ex_mem_read_d;
         ex_src1_q     <= ex_src1_d;
         ex_src2_q     <= ex_src2_d;
      end
   end

   assign ex_valid_o  = ex_valid_q;
   assign ex_pc       = ex_pc_q;
   assign ex_alu_op   = ex_alu_op_q;
   assign ex_imm      = ex_imm_q;
   assign ex_wreg     = ex_wreg_q;
   assign ex_waddr    = ex_waddr_q;
   assign ex_mem_read = ex_mem_read_q;
   assign ex_src1     = ex_src1_q;
   assign ex_src2     = ex_src2_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized scoreboard bench for the ID->EX pipeline register
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst, flush, id_valid_i, id_ready_o;
   logic [31:0] id_pc, id_rdata1, id_rdata2, id_imm, ex_fwd_data, mem_fwd_wdata;
   logic [7:0]  id_alu_op;
   logic        id_re1, id_re2, id_wreg, id_mem_read, mem_fwd_we;
   logic [4:0]  id_raddr1, id_raddr2, id_waddr, mem_fwd_waddr;
   logic        ex_valid_o, ex_ready_i, ex_wreg, ex_mem_read;
   logic [31:0] ex_pc, ex_imm, ex_src1, ex_src2;
   logic [7:0]  ex_alu_op;
   logic [4:0]  ex_waddr;

   typedef struct {
      logic [31:0] pc;
      logic [7:0]  op;
      logic [31:0] imm;
      logic        wreg;
      logic [4:0]  waddr;
      logic        mr;
      logic [31:0] s1;
      logic [31:0] s2;
   } ent_t;

   ent_t q[$];
   ent_t held;
   bit   held_v = 0;
   bit   exp_ready = 1;
   int   tests = 0, fails = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
      .id_pc(id_pc), .id_alu_op(id_alu_op), .id_re1(id_re1), .id_re2(id_re2),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_wreg(id_wreg), .id_waddr(id_waddr), .id_mem_read(id_mem_read),
      .ex_fwd_data(ex_fwd_data), .mem_fwd_we(mem_fwd_we), .mem_fwd_waddr(mem_fwd_waddr),
      .mem_fwd_wdata(mem_fwd_wdata), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_pc(ex_pc), .ex_alu_op(ex_alu_op), .ex_imm(ex_imm), .ex_wreg(ex_wreg),
      .ex_waddr(ex_waddr), .ex_mem_read(ex_mem_read), .ex_src1(ex_src1), .ex_src2(ex_src2)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // operand value the ISA says the consumer must see, given what the stage holds
   function automatic logic [31:0] opnd(logic re, logic [4:0] a, logic [31:0] rd);
      if (!re || a == 0) return 0;
      if (held_v && held.wreg && !held.mr && held.waddr == a) return ex_fwd_data;
      if (mem_fwd_we && mem_fwd_waddr == a) return mem_fwd_wdata;
      return rd;
   endfunction

   // predict this cycle's outcome from current inputs, then advance one clock
   task automatic cycle();
      bit   hz, fin, fout;
      ent_t n;
      hz = id_valid_i && held_v && held.mr && held.wreg && held.waddr != 0 &&
           ((id_re1 && id_raddr1 == held.waddr) || (id_re2 && id_raddr2 == held.waddr));
      exp_ready = !flush && !hz && (!held_v || ex_ready_i);
      fin  = id_valid_i && exp_ready;
      fout = held_v && ex_ready_i;
      n = '{id_pc, id_alu_op, id_imm, id_wreg, id_waddr, id_mem_read,
            opnd(id_re1, id_raddr1, id_rdata1), opnd(id_re2, id_raddr2, id_rdata2)};
      @(posedge clk);
      if (rst) begin
         held_v = 0;
         q.delete();
      end else if (flush) begin
         if (held_v && !fout && q.size() > 0) void'(q.pop_front());
         held_v = 0;
      end else if (fin) begin
         held = n;
         held_v = 1;
         q.push_back(n);
      end else if (fout) held_v = 0;
      #1;
   endtask

   task automatic idle();
      flush = 0; id_valid_i = 0; id_re1 = 0; id_re2 = 0; id_wreg = 0; id_mem_read = 0;
      id_raddr1 = 0; id_raddr2 = 0; id_waddr = 0; mem_fwd_we = 0; mem_fwd_waddr = 0;
      ex_ready_i = 1; id_pc = 0; id_alu_op = 0; id_imm = 0; id_rdata1 = 0; id_rdata2 = 0;
      ex_fwd_data = 0; mem_fwd_wdata = 0;
   endtask

   task automatic issue(logic [31:0] pc, logic re1, logic [4:0] a1, logic re2, logic [4:0] a2,
                        logic wr, logic [4:0] wa, logic mr);
      id_valid_i = 1; id_pc = pc; id_alu_op = pc[7:0]; id_imm = ~pc;
      id_re1 = re1; id_raddr1 = a1; id_re2 = re2; id_raddr2 = a2;
      id_wreg = wr; id_waddr = wa; id_mem_read = mr;
   endtask

   // monitor: every cycle compare handshake outputs, and the presented entry against the queue head
   always @(negedge clk) begin
      chk("ex_valid", 32'(ex_valid_o), 32'(held_v));
      chk("id_ready", 32'(id_ready_o), 32'(exp_ready));
      if (ex_valid_o) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: got valid output, expected none at %0t", $time);
         end else begin
            chk("pc",    ex_pc,              q[0].pc);
            chk("op",    32'(ex_alu_op),     32'(q[0].op));
            chk("imm",   ex_imm,             q[0].imm);
            chk("ctl",   {ex_wreg, ex_mem_read, ex_waddr}, {q[0].wreg, q[0].mr, q[0].waddr});
            chk("src1",  ex_src1,            q[0].s1);
            chk("src2",  ex_src2,            q[0].s2);
            if (ex_ready_i) void'(q.pop_front());
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      cycle(); cycle();
      rst = 0;
      chk("rst_valid", 32'(ex_valid_o), 0);
      chk("rst_src1", ex_src1, 0);
      chk("rst_pc", ex_pc, 0);
      chk("rst_ready", 32'(id_ready_o), 1);
      // plain pass
      issue(32'h100, 1, 3, 0, 0, 1, 7, 0); id_rdata1 = 32'h11;
      cycle();
      chk("pass_src1", ex_src1, 32'h11);
      chk("pass_valid", 32'(ex_valid_o), 1);
      // EX forward beats MEM forward
      issue(32'h104, 0, 0, 0, 0, 1, 5, 0);
      cycle();
      issue(32'h108, 1, 5, 0, 0, 0, 0, 0); ex_fwd_data = 32'hAA;
      mem_fwd_we = 1; mem_fwd_waddr = 5; mem_fwd_wdata = 32'hBB;
      cycle();
      chk("exfwd_src1", ex_src1, 32'hAA);
      // load-use: one bubble, then accept with MEM data
      mem_fwd_we = 0;
      issue(32'h10C, 0, 0, 0, 0, 1, 4, 1);
      cycle();
      issue(32'h110, 1, 4, 0, 0, 1, 9, 0); id_rdata1 = 32'h1234;
      #1 chk("lu_ready", 32'(id_ready_o), 0);
      cycle();
      chk("lu_bubble", 32'(ex_valid_o), 0);
      mem_fwd_we = 1; mem_fwd_waddr = 4; mem_fwd_wdata = 32'h44;
      cycle();
      chk("lu_src1", ex_src1, 32'h44);
      chk("lu_valid", 32'(ex_valid_o), 1);
      // $zero never forwards
      issue(32'h114, 0, 0, 1, 0, 0, 0, 0); id_rdata2 = 32'h77;
      mem_fwd_waddr = 0; mem_fwd_wdata = 32'hFF;
      cycle();
      chk("zero_src2", ex_src2, 0);
      // backpressure then flush
      mem_fwd_we = 0; ex_ready_i = 0;
      issue(32'h118, 1, 2, 0, 0, 0, 0, 0);
      repeat (3) begin
         cycle();
         chk("bp_pc", ex_pc, 32'h114);
      end
      flush = 1; id_pc = 32'hDEAD;
      cycle();
      chk("fl_valid", 32'(ex_valid_o), 0);
      chk("fl_pc", ex_pc, 32'h114);
      idle();
      cycle();
      // randomized traffic over a small register window to provoke hazards
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 63) == 0);
         flush         = ($urandom_range(0, 15) == 0);
         id_valid_i    = ($urandom_range(0, 3) != 0);
         ex_ready_i    = ($urandom_range(0, 3) != 0);
         id_pc         = $urandom; id_alu_op = 8'($urandom); id_imm = $urandom;
         id_re1        = 1'($urandom); id_re2 = 1'($urandom);
         id_raddr1     = 5'($urandom_range(0, 7)); id_raddr2 = 5'($urandom_range(0, 7));
         id_rdata1     = $urandom; id_rdata2 = $urandom;
         id_wreg       = ($urandom_range(0, 3) != 0);
         id_waddr      = 5'($urandom_range(0, 7));
         id_mem_read   = 1'($urandom);
         ex_fwd_data   = $urandom;
         mem_fwd_we    = 1'($urandom);
         mem_fwd_waddr = 5'($urandom_range(0, 7));
         mem_fwd_wdata = $urandom;
         cycle();
      end
      rst = 0;
      idle();
      cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
